// File: rtl/sata_oob_pkg.sv
// Shared definitions for the host-side SATA OOB sequencer: state encodings,
// UIOOB-to-clock conversion and default timing constants.
package sata_oob_pkg;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_COMRESET     = 4'd1,
        ST_WAIT_COMINIT = 4'd2,
        ST_COMWAKE      = 4'd3,
        ST_WAIT_COMWAKE = 4'd4,
        ST_WAIT_RELEASE = 4'd5,
        ST_WAIT_ALIGN   = 4'd6,
        ST_SEND_ALIGN   = 4'd7,
        ST_LINK_UP      = 4'd8
    } oob_state_e;

    // OOB signalling durations expressed in UIOOB (666.67 ps each)
    localparam int UIOOB_BURST      = 160;
    localparam int UIOOB_RESET_IDLE = 480;
    localparam int UIOOB_WAKE_IDLE  = 160;

    // One UIOOB is 2/3 of a 1 ns clock period; round to the nearest clock.
    function automatic int uioob_to_cyc(input int uioob);
        return (uioob * 2 + 1) / 3;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int C_BURST_CYC       = uioob_to_cyc(UIOOB_BURST);
    localparam int C_RESET_IDLE_CYC  = uioob_to_cyc(UIOOB_RESET_IDLE);
    localparam int C_WAKE_IDLE_CYC   = uioob_to_cyc(UIOOB_WAKE_IDLE);
    localparam int C_NBURST          = 6;
    localparam int C_COMINIT_TIMEOUT = 1_000_000;
    localparam int C_ALIGN_TIMEOUT   = 880_000;
    localparam int C_NONALIGN_N      = 3;
    localparam int C_RETRY_W         = 8;

endpackage

// File: rtl/sata_oob_burst_gen.sv
// Burst/idle pattern engine shared by COMRESET and COMWAKE: P_NBURST pairs
// of a fixed-length burst followed by a selectable-length idle gap.
module sata_oob_burst_gen
    import sata_oob_pkg::*;
#(
    parameter int P_BURST_CYC      = C_BURST_CYC,
    parameter int P_RESET_IDLE_CYC = C_RESET_IDLE_CYC,
    parameter int P_WAKE_IDLE_CYC  = C_WAKE_IDLE_CYC,
    parameter int P_NBURST         = C_NBURST
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    input  logic idle_sel,
    output logic burst,
    output logic elecidle,
    output logic done
);

    localparam int MAX_PHASE = max2(P_BURST_CYC, max2(P_RESET_IDLE_CYC, P_WAKE_IDLE_CYC));
    localparam int CYC_W     = $clog2(MAX_PHASE + 1);
    localparam int NB_W      = $clog2(P_NBURST + 1);

    localparam logic [CYC_W-1:0] BURST_LAST      = CYC_W'(P_BURST_CYC - 1);
    localparam logic [CYC_W-1:0] RESET_IDLE_LAST = CYC_W'(P_RESET_IDLE_CYC - 1);
    localparam logic [CYC_W-1:0] WAKE_IDLE_LAST  = CYC_W'(P_WAKE_IDLE_CYC - 1);
    localparam logic [NB_W-1:0]  NB_LAST         = NB_W'(P_NBURST - 1);

    logic             active_reg;
    logic             in_burst_reg;
    logic             sel_reg;
    logic [CYC_W-1:0] cyc_reg;
    logic [NB_W-1:0]  nb_reg;
    logic [CYC_W-1:0] idle_last;

    assign idle_last = sel_reg ? WAKE_IDLE_LAST : RESET_IDLE_LAST;

    // start wins over run so a fresh sequence can begin on the entry edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_reg   <= 1'b0;
            in_burst_reg <= 1'b0;
            sel_reg      <= 1'b0;
            cyc_reg      <= '0;
            nb_reg       <= '0;
        end else if (start) begin
            active_reg   <= 1'b1;
            in_burst_reg <= 1'b1;
            sel_reg      <= idle_sel;
            cyc_reg      <= '0;
            nb_reg       <= '0;
        end else if (!run) begin
            active_reg   <= 1'b0;
            in_burst_reg <= 1'b0;
        end else if (active_reg) begin
            if (in_burst_reg) begin
                if (cyc_reg == BURST_LAST) begin
                    in_burst_reg <= 1'b0;
                    cyc_reg      <= '0;
                end else begin
                    cyc_reg <= cyc_reg + CYC_W'(1);
                end
            end else if (cyc_reg == idle_last) begin
                cyc_reg <= '0;
                if (nb_reg == NB_LAST) begin
                    active_reg <= 1'b0;
                end else begin
                    nb_reg       <= nb_reg + NB_W'(1);
                    in_burst_reg <= 1'b1;
                end
            end else begin
                cyc_reg <= cyc_reg + CYC_W'(1);
            end
        end
    end

    assign burst    = active_reg & in_burst_reg;
    assign elecidle = ~burst;
    assign done     = active_reg & ~in_burst_reg & (cyc_reg == idle_last) & (nb_reg == NB_LAST);

endmodule

// File: rtl/sata_oob_ctrl.sv
// Host-side SATA OOB link-initialization sequencer: COMRESET/COMWAKE
// generation, device handshake, ALIGN exchange and link-up indication.
module sata_oob_ctrl
    import sata_oob_pkg::*;
#(
    parameter int P_BURST_CYC       = C_BURST_CYC,
    parameter int P_RESET_IDLE_CYC  = C_RESET_IDLE_CYC,
    parameter int P_WAKE_IDLE_CYC   = C_WAKE_IDLE_CYC,
    parameter int P_NBURST          = C_NBURST,
    parameter int P_COMINIT_TIMEOUT = C_COMINIT_TIMEOUT,
    parameter int P_ALIGN_TIMEOUT   = C_ALIGN_TIMEOUT,
    parameter int P_NONALIGN_N      = C_NONALIGN_N,
    parameter int P_RETRY_W         = C_RETRY_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_enable,
    input  logic                 i_cominit_det,
    input  logic                 i_comwake_det,
    input  logic                 i_rx_align,
    input  logic                 i_rx_prim,
    output logic                 o_tx_burst,
    output logic                 o_tx_elecidle,
    output logic                 o_tx_align,
    output logic                 o_link_up,
    output logic [3:0]           o_state,
    output logic [P_RETRY_W-1:0] o_retry_cnt
);

    localparam int TMR_W = $clog2(max2(P_COMINIT_TIMEOUT, P_ALIGN_TIMEOUT) + 1);
    localparam int NA_W  = $clog2(P_NONALIGN_N + 1);

    localparam logic [TMR_W-1:0] COMINIT_LAST = TMR_W'(P_COMINIT_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] ALIGN_LAST   = TMR_W'(P_ALIGN_TIMEOUT - 1);
    localparam logic [NA_W-1:0]  NA_LAST      = NA_W'(P_NONALIGN_N - 1);

    oob_state_e           state_reg;
    oob_state_e           state_next;
    logic [TMR_W-1:0]     timer_reg;
    logic [NA_W-1:0]      na_cnt_reg;
    logic [P_RETRY_W-1:0] retry_reg;
    logic                 cominit_prev_reg;
    logic                 retry_inc;
    logic                 state_change;
    logic                 cominit_rise;

    logic gen_start;
    logic gen_run;
    logic gen_idle_sel;
    logic gen_burst;
    logic gen_elecidle;
    logic gen_done;

    assign state_change = (state_next != state_reg);
    assign cominit_rise = i_cominit_det & ~cominit_prev_reg;

    // The engine is launched on the same edge the FSM enters a burst state,
    // so the first burst clock coincides with the first clock of that state.
    assign gen_run      = (state_next == ST_COMRESET) || (state_next == ST_COMWAKE);
    assign gen_start    = gen_run && state_change;
    assign gen_idle_sel = (state_next == ST_COMWAKE);

    sata_oob_burst_gen #(
        .P_BURST_CYC      (P_BURST_CYC),
        .P_RESET_IDLE_CYC (P_RESET_IDLE_CYC),
        .P_WAKE_IDLE_CYC  (P_WAKE_IDLE_CYC),
        .P_NBURST         (P_NBURST)
    ) u_burst_gen (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .start    (gen_start),
        .run      (gen_run),
        .idle_sel (gen_idle_sel),
        .burst    (gen_burst),
        .elecidle (gen_elecidle),
        .done     (gen_done)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        retry_inc  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_enable) state_next = ST_COMRESET;
            end
            ST_COMRESET: begin
                if (gen_done) state_next = ST_WAIT_COMINIT;
            end
            ST_WAIT_COMINIT: begin
                if (i_cominit_det) begin
                    state_next = ST_COMWAKE;
                end else if (timer_reg == COMINIT_LAST) begin
                    state_next = ST_COMRESET;
                    retry_inc  = 1'b1;
                end
            end
            ST_COMWAKE: begin
                if (gen_done) state_next = ST_WAIT_COMWAKE;
            end
            ST_WAIT_COMWAKE: begin
                if (i_comwake_det) begin
                    state_next = ST_WAIT_RELEASE;
                end else if (timer_reg == COMINIT_LAST) begin
                    state_next = ST_COMRESET;
                    retry_inc  = 1'b1;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!i_comwake_det) state_next = ST_WAIT_ALIGN;
            end
            ST_WAIT_ALIGN: begin
                if (i_rx_align) begin
                    state_next = ST_SEND_ALIGN;
                end else if (timer_reg == ALIGN_LAST) begin
                    state_next = ST_COMRESET;
                    retry_inc  = 1'b1;
                end
            end
            ST_SEND_ALIGN: begin
                if (!i_rx_align && i_rx_prim && (na_cnt_reg == NA_LAST))
                    state_next = ST_LINK_UP;
            end
            ST_LINK_UP: begin
                if (cominit_rise) state_next = ST_COMWAKE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (!i_enable) begin
            state_next = ST_IDLE;
            retry_inc  = 1'b0;
        end
    end

    // Saturating so a long stay in LINK_UP cannot wrap into a false timeout
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer_reg <= '0;
        end else if (state_change) begin
            timer_reg <= '0;
        end else if (timer_reg != '1) begin
            timer_reg <= timer_reg + TMR_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            na_cnt_reg <= '0;
        end else if (state_change || (state_reg != ST_SEND_ALIGN) || i_rx_align) begin
            na_cnt_reg <= '0;
        end else if (i_rx_prim) begin
            na_cnt_reg <= na_cnt_reg + NA_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retry_reg        <= '0;
            cominit_prev_reg <= 1'b0;
        end else begin
            cominit_prev_reg <= i_cominit_det;
            if (retry_inc && (retry_reg != '1))
                retry_reg <= retry_reg + P_RETRY_W'(1);
        end
    end

    always_comb begin
        o_tx_burst    = 1'b0;
        o_tx_elecidle = 1'b1;
        o_tx_align    = 1'b0;
        o_link_up     = 1'b0;
        case (state_reg)
            ST_COMRESET, ST_COMWAKE: begin
                o_tx_burst    = gen_burst;
                o_tx_elecidle = gen_elecidle;
            end
            ST_WAIT_ALIGN: begin
                o_tx_elecidle = 1'b0;
            end
            ST_SEND_ALIGN: begin
                o_tx_elecidle = 1'b0;
                o_tx_align    = 1'b1;
            end
            ST_LINK_UP: begin
                o_tx_elecidle = 1'b0;
                o_link_up     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_state     = state_reg;
    assign o_retry_cnt = retry_reg;

endmodule

// File: doc/sata_oob_ctrl.md
Name: sata_oob_ctrl

Overview:
Host-side SATA out-of-band (OOB) link-initialization sequencer. It drives the PHY transmitter's burst and electrical-idle controls to generate COMRESET and COMWAKE. It consumes RX-side COMINIT/COMWAKE detectors and primitive detectors, then performs the ALIGN/SYNC handshake and asserts link-up. It sits between the PHY/OOB detector and the link layer, and is the block that raises the link-layer-up indication consumed by the bench models.

Parameters:
- P_BURST_CYC, 107: clocks per OOB burst (160 UIOOB).
- P_RESET_IDLE_CYC, 320: clocks of idle between COMRESET bursts (480 UIOOB).
- P_WAKE_IDLE_CYC, 107: clocks of idle between COMWAKE bursts (160 UIOOB).
- P_NBURST, 6: bursts per COMRESET/COMWAKE.
- P_COMINIT_TIMEOUT, 1_000_000: clocks to wait for COMINIT or COMWAKE before restarting at COMRESET.
- P_ALIGN_TIMEOUT, 880_000: clocks to wait for first RX ALIGN (880 us) before restarting.
- P_NONALIGN_N, 3: consecutive non-ALIGN primitives required for link-up.
- P_RETRY_W, 8: width of the retry counter.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_enable, input, 1: start/hold; low forces IDLE.
- i_cominit_det, input, 1: level; device COMINIT detected.
- i_comwake_det, input, 1: level; device COMWAKE detected.
- i_rx_align, input, 1: one-cycle strobe; valid ALIGN primitive received.
- i_rx_prim, input, 1: one-cycle strobe; valid non-ALIGN primitive received.
- o_tx_burst, output, 1: PHY drives OOB burst pattern.
- o_tx_elecidle, output, 1: PHY electrical idle.
- o_tx_align, output, 1: PHY transmits ALIGN primitives.
- o_link_up, output, 1: OOB complete; link layer may run.
- o_state, output, 4: current state encoding, for debug.
- o_retry_cnt, output, P_RETRY_W: count of restarts, saturating.

Behaviour:
- Reset values: o_tx_burst=0, o_tx_elecidle=1, o_tx_align=0, o_link_up=0, o_state=IDLE(0), o_retry_cnt=0. All counters are cleared.
- All outputs are registered and decoded from the state and phase registers. There are no combinational input-to-output paths.
- States (encoding): IDLE=0, COMRESET=1, WAIT_COMINIT=2, COMWAKE=3, WAIT_COMWAKE=4, WAIT_RELEASE=5, WAIT_ALIGN=6, SEND_ALIGN=7, LINK_UP=8.
- IDLE: elecidle=1. When i_enable=1, go to COMRESET on the next clock.
- COMRESET/COMWAKE burst engine:
  - The sequence is P_NBURST pairs of (burst, idle). Burst phase: o_tx_burst=1 and o_tx_elecidle=0 for exactly P_BURST_CYC clocks. Idle phase: o_tx_burst=0 and o_tx_elecidle=1 for P_RESET_IDLE_CYC (COMRESET) or P_WAKE_IDLE_CYC (COMWAKE) clocks.
  - After the last idle, move to WAIT_COMINIT or WAIT_COMWAKE respectively.
  - Total state durations are P_NBURST*(P_BURST_CYC+idle) clocks.
  - Detector inputs are ignored while bursting.
- WAIT_COMINIT:
  - Waits for the first clock with i_cominit_det=1, then goes to COMWAKE.
  - Timeout after P_COMINIT_TIMEOUT clocks: go to COMRESET and increment o_retry_cnt.
- WAIT_COMWAKE: same as WAIT_COMINIT, but waits on i_comwake_det and goes to WAIT_RELEASE.
- WAIT_RELEASE: elecidle=1. Waits for i_comwake_det=0, then goes to WAIT_ALIGN. No timeout.
- WAIT_ALIGN:
  - elecidle=0 and o_tx_align=0; the PHY sends D10.2.
  - On the first i_rx_align, go to SEND_ALIGN.
  - Timeout after P_ALIGN_TIMEOUT clocks: go to COMRESET with retry++.
- SEND_ALIGN:
  - o_tx_align=1.
  - A non-ALIGN counter increments on i_rx_prim and clears on i_rx_align.
  - When P_NONALIGN_N is reached, go to LINK_UP.
  - If i_rx_align and i_rx_prim are both asserted in one cycle, i_rx_align wins (clear).
- LINK_UP: o_link_up=1 and o_tx_align=0.
  - A new i_cominit_det=1 rising edge (device-initiated reset) clears o_link_up and goes to COMWAKE, with no retry increment.
- i_enable=0 in any state: go to IDLE next clock, with outputs at reset values except o_retry_cnt, which is retained.
- o_retry_cnt saturates at all-ones and never wraps.
- Timeout counters clear on every state entry. They are wide enough for the max parameter, computed with $clog2 of the max timeout plus 1.
- Asynchronous reset takes effect mid-burst: o_tx_burst drops immediately.

Decomposition:
- Shared package sata_oob_pkg holds the state encodings and UIOOB-to-clock conversion constants, which are reused by the bench COMINIT/COMWAKE models.
- One sub-module, sata_oob_burst_gen: the burst/idle counter engine.
  - Inputs: start, idle length select, P_BURST_CYC, P_NBURST.
  - Outputs: burst, elecidle, done pulse.
  - It is instantiated once and shared by COMRESET and COMWAKE.

Test Plan (bench params: P_BURST_CYC=4, P_RESET_IDLE_CYC=12, P_WAKE_IDLE_CYC=4, P_NBURST=6, timeouts=200, P_NONALIGN_N=3):
- Reset release with i_enable=1:
  - o_tx_burst shows 6 high pulses of 4 clocks, separated by 12 low clocks.
  - o_state=2 exactly 96 clocks after entering COMRESET.
- Nominal bring-up sequence:
  - Stimulus: COMINIT 10 clocks after WAIT_COMINIT; COMWAKE detected, then deasserted; ALIGN strobe; then 3 i_rx_prim.
  - Response: COMWAKE shows 6×(4 high, 4 low); o_tx_align rises 1 clock after the ALIGN strobe; o_link_up=1 one clock after the 3rd prim.
- No COMINIT:
  - After 200 clocks in WAIT_COMINIT, o_state=1 and o_retry_cnt=1.
  - Repeat 256 times: o_retry_cnt holds at 255.
- In SEND_ALIGN, sequence prim, prim, ALIGN, prim, prim, prim: link-up only after the final prim, since the counter reset on the ALIGN.
- In LINK_UP, pulse i_cominit_det: o_link_up=0 next clock, o_state=3, o_retry_cnt unchanged.
- Stress mid-burst: assert i_rst_n=0 at the 2nd burst clock, and separately drop i_enable mid-COMWAKE.
  - i_rst_n=0: o_tx_burst=0 asynchronously.
  - i_enable=0: o_state=0 the following clock.
